// File: rtl/flag_pkg.sv
// flag_pkg: branch-type and condition encodings plus NZCV bit positions
// shared by the branch controller and the fetch unit.
package flag_pkg;
    typedef enum logic [1:0] {BR_NONE, BR_CBZ, BR_CBNZ, BR_BCOND} br_type_e;
    typedef enum logic [3:0] {EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-code test against an NZCV nibble.
module cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v, base;
    always_comb begin
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = n == v;
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        // Odd codes are the negation of their pair, except NV which is also always-true.
        pass = (cond[0] && cond != NV) ? ~base : base;
    end
endmodule

// File: rtl/zero_checker.sv
// zero_checker: flags an all-zero datapath word, reduced per 64-bit lane.
module zero_checker #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] data,
    output logic             zero
);
    logic [WIDTH/64-1:0] lane_nz;
    for (genvar i = 0; i < WIDTH / 64; i++) begin : g_lane
        assign lane_nz[i] = |data[i*64 +: 64];
    end
    assign zero = ~|lane_nz;
endmodule

// File: rtl/flag_branch_ctrl.sv
// flag_branch_ctrl: 2-stage valid/ready pipe taking ALU results through zero
// detection and NZCV capture, resolving CBZ/CBNZ/B.cond with flag forwarding.
module flag_branch_ctrl
    import flag_pkg::*;
#(
    parameter int         WIDTH    = 64,
    parameter logic [3:0] FLAG_RST = 4'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             set_flags,
    input  logic [1:0]       br_type,
    input  logic [3:0]       cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_taken,
    output logic             is_zero,
    output logic [3:0]       flags
);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s1_result_q, s1_result_d;
    logic             s1_carry_q, s1_carry_d, s1_ovf_q, s1_ovf_d, s1_set_q, s1_set_d;
    br_type_e         s1_br_q, s1_br_d;
    logic [3:0]       s1_cond_q, s1_cond_d;
    logic             s2_set_q, s2_set_d, br_taken_q, br_taken_d, is_zero_q, is_zero_d;
    logic [3:0]       s2_nzcv_q, s2_nzcv_d, flags_q, flags_d;
    logic             s1_load, s2_load, s1_zero, cond_pass;
    logic [3:0]       s1_nzcv, eff_flags;

    zero_checker #(.WIDTH(WIDTH)) u_zero (.data(s1_result_q), .zero(s1_zero));
    cond_eval u_cond (.cond(s1_cond_q), .nzcv(eff_flags), .pass(cond_pass));

    assign in_ready  = ~s2_valid_q | out_ready | ~s1_valid_q;
    assign s1_load   = in_valid & in_ready;
    assign s2_load   = s1_valid_q & (~s2_valid_q | out_ready);
    // Only the op sitting in S2 can be older than the S1 op yet missing from flags_q.
    assign eff_flags = (s2_valid_q & s2_set_q) ? s2_nzcv_q : flags_q;

    always_comb begin
        s1_valid_d  = s1_load | (s1_valid_q & ~s2_load);
        s1_result_d = s1_load ? alu_result : s1_result_q;
        s1_carry_d  = s1_load ? alu_carry : s1_carry_q;
        s1_ovf_d    = s1_load ? alu_overflow : s1_ovf_q;
        s1_set_d    = s1_load ? set_flags : s1_set_q;
        s1_br_d     = s1_load ? br_type_e'(br_type) : s1_br_q;
        s1_cond_d   = s1_load ? cond : s1_cond_q;
        s1_nzcv     = {s1_result_q[WIDTH-1], s1_zero, s1_carry_q, s1_ovf_q};
        s2_valid_d  = s2_load | (s2_valid_q & ~out_ready);
        s2_set_d    = s2_load ? s1_set_q : s2_set_q;
        s2_nzcv_d   = s2_load ? s1_nzcv : s2_nzcv_q;
        is_zero_d   = s2_load ? s1_zero : is_zero_q;
        br_taken_d  = s2_load ? ((s1_br_q == BR_CBZ)  ? s1_zero :
                                 (s1_br_q == BR_CBNZ) ? ~s1_zero :
                                 (s1_br_q == BR_BCOND) & cond_pass) : br_taken_q;
        flags_d     = (s2_valid_q & out_ready & s2_set_q) ? s2_nzcv_q : flags_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_result_q <= '0;
            s1_carry_q  <= 1'b0;
            s1_ovf_q    <= 1'b0;
            s1_set_q    <= 1'b0;
            s1_br_q     <= BR_NONE;
            s1_cond_q   <= 4'b0;
            s2_valid_q  <= 1'b0;
            s2_set_q    <= 1'b0;
            s2_nzcv_q   <= 4'b0;
            br_taken_q  <= 1'b0;
            is_zero_q   <= 1'b0;
            flags_q     <= FLAG_RST;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_result_q <= s1_result_d;
            s1_carry_q  <= s1_carry_d;
            s1_ovf_q    <= s1_ovf_d;
            s1_set_q    <= s1_set_d;
            s1_br_q     <= s1_br_d;
            s1_cond_q   <= s1_cond_d;
            s2_valid_q  <= s2_valid_d;
            s2_set_q    <= s2_set_d;
            s2_nzcv_q   <= s2_nzcv_d;
            br_taken_q  <= br_taken_d;
            is_zero_q   <= is_zero_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign br_taken  = br_taken_q;
    assign is_zero   = is_zero_q;
    assign flags     = flags_q;
endmodule
